rsa_xcel_naive_mulrem: RTL and testbench
========================================

RSA_XCEL_NAIVE_MULREM -- requirements
Module: rsa_xcel_naive_mulrem

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state updates on posedge.
REQ-002 SHALL have: reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-003 SHALL have: istream_val  input  1  request valid.
REQ-004 SHALL have: istream_rdy  output  1  unit ready to accept a request.
REQ-005 SHALL have: istream_a  input  32  multiplicand; caller guarantees a < n.
REQ-006 SHALL have: istream_b  input  32  multiplier; any value.
REQ-007 SHALL have: istream_n  input  32  modulus.
REQ-008 SHALL have: ostream_val  output  1  result valid.
REQ-009 SHALL have: ostream_rdy  input  1  consumer ready.
REQ-010 SHALL have: ostream_msg  output  32  result (a*b) mod n.

Function
REQ-011 SHALL be a three-state FSM: IDLE, CALC, DONE.
REQ-012 SHALL drive istream_rdy = 1 only in IDLE and ostream_val = 1 only in DONE, both as pure state decodes with no combinational path from istream_val or ostream_rdy.
REQ-013 SHALL treat a transfer as complete on a posedge where val and rdy are both 1; istream_val may depend combinationally on istream_rdy, and ostream_rdy may depend combinationally on ostream_val.
REQ-014 In IDLE, on an accepted request, SHALL load A_reg = a, B_reg = b, N_reg = n, R_reg = 0, iteration counter = 0, and go to CALC.
REQ-015 Each CALC cycle SHALL do the following:
 - if B_reg[0], R_reg <= (R_reg + A_reg) mod N_reg, using one conditional subtract of N_reg;
 - A_reg <= (2*A_reg) mod N_reg, using one conditional subtract;
 - B_reg <= B_reg >> 1;
 - counter <= counter + 1.
REQ-016 Intermediate sums SHALL be computed at 33 bits so that no overflow occurs for N_reg up to 0xFFFFFFFF.
REQ-017 CALC SHALL go to DONE after the 32nd iteration (counter wraps from 31); with the feature of REQ-026 enabled, it SHALL also go to DONE after any iteration whose shifted B_reg is 0.
REQ-018 Default latency SHALL be: request accepted at edge T, ostream_val = 1 from cycle T+33.
REQ-019 In DONE, ostream_msg SHALL equal R_reg and SHALL hold stable until the transfer completes; the FSM SHALL then return to IDLE on that edge.
REQ-020 If N_reg == 0, ostream_msg SHALL be 0 with normal latency.
REQ-021 If a >= n, the result is unspecified, but the handshake and latency SHALL be unchanged.
REQ-022 Requests presented while not in IDLE SHALL be ignored, since istream_rdy = 0.
REQ-023 Back-to-back operation: the earliest next accept is one cycle after the output transfer, because IDLE lasts at least one cycle.

Reset
REQ-024 Asserting reset (low) SHALL force IDLE immediately, regardless of clock, including mid-CALC or DONE; any in-flight result is discarded.
REQ-025 During reset: istream_rdy = 1, ostream_val = 0, ostream_msg = 0; counter and all data registers = 0.

Configuration
REQ-026 Macro RSA_XCEL_NAIVE_MULREM_EARLY_EXIT_EN:
 - when defined, CALC SHALL terminate once the remaining multiplier is 0, giving max(1, bitlength(b)) CALC cycles;
 - when undefined, CALC SHALL always run exactly 32 cycles;
 - results SHALL be identical in both builds.

Verification
REQ-027 a=7, b=5, n=13, ostream_rdy=1 -> ostream_msg=9; ostream_val first high 33 cycles after accept (macro off).
REQ-028 a=0xFFFFFFFE, b=0xFFFFFFFE, n=0xFFFFFFFF -> ostream_msg=1, with no 32-bit overflow error.
REQ-029 a=12, b=1, n=13 with ostream_rdy held low 5 cycles in DONE -> ostream_val stays 1, ostream_msg stays 12, istream_rdy stays 0; returns to IDLE the cycle after ostream_rdy rises.
REQ-030 Macro on: b=0 -> result 0 with ostream_val 2 cycles after accept; b=5 -> ostream_val 4 cycles after accept (3 CALC cycles).
REQ-031 reset pulsed low at CALC iteration 10 of a=3, b=9, n=7 -> ostream_val=0 and istream_rdy=1 immediately; a new request a=3, b=9, n=7 then yields 6.
REQ-032 n=0, a=0, b=0x1234 -> ostream_msg=0 with normal latency.

Source files
------------

// File: rtl/rsa_xcel_naive_mulrem.sv
// Iterative (a*b) mod n unit: shift-and-add multiply with one conditional subtract per step.
// Optional RSA_XCEL_NAIVE_MULREM_EARLY_EXIT_EN stops iterating once the remaining multiplier is zero.
module rsa_xcel_naive_mulrem (
    input  logic        clk,
    input  logic        reset,
    input  logic        istream_val,
    output logic        istream_rdy,
    input  logic [31:0] istream_a,
    input  logic [31:0] istream_b,
    input  logic [31:0] istream_n,
    output logic        ostream_val,
    input  logic        ostream_rdy,
    output logic [31:0] ostream_msg
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] n_q, n_d;
    logic [31:0] r_q, r_d;
    logic [4:0]  cnt_q, cnt_d;

    logic [32:0] r_sum, a_dbl;
    logic        r_ge, a_ge;
    logic [31:0] r_next, a_next;
    logic        last_iter;

    // Both operands are below n, so the 33-bit sum is below 2n and one subtract suffices;
    // the reduced value fits in 32 bits, so the low-half subtraction is exact.
    always_comb begin
        r_sum  = {1'b0, r_q} + {1'b0, a_q};
        r_ge   = (r_sum >= {1'b0, n_q});
        r_next = r_ge ? (r_sum[31:0] - n_q) : r_sum[31:0];
        a_dbl  = {a_q, 1'b0};
        a_ge   = (a_dbl >= {1'b0, n_q});
        a_next = a_ge ? (a_dbl[31:0] - n_q) : a_dbl[31:0];
    end

`ifdef RSA_XCEL_NAIVE_MULREM_EARLY_EXIT_EN
    assign last_iter = (cnt_q == 5'd31) || (b_q[31:1] == 31'd0);
`else
    assign last_iter = (cnt_q == 5'd31);
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        n_d     = n_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (istream_val) begin
                    a_d     = istream_a;
                    b_d     = istream_b;
                    n_d     = istream_n;
                    r_d     = 32'd0;
                    cnt_d   = 5'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // A zero modulus pins the result at zero.
                if (b_q[0]) r_d = (n_q == 32'd0) ? 32'd0 : r_next;
                a_d   = a_next;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 5'd1;
                if (last_iter) state_d = DONE;
            end
            DONE: begin
                if (ostream_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            n_q     <= 32'd0;
            r_q     <= 32'd0;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            n_q     <= n_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
        end
    end

    assign istream_rdy = (state_q == IDLE);
    assign ostream_val = (state_q == DONE);
    assign ostream_msg = (state_q == DONE) ? r_q : 32'd0;

endmodule

// File: tb/tb_rsa_xcel_naive_mulrem.sv
// Directed table-driven bench for rsa_xcel_naive_mulrem, plus back-pressure and mid-run reset sequences.
module tb_rsa_xcel_naive_mulrem;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        istream_val = 1'b0;
    logic        istream_rdy;
    logic [31:0] istream_a = 32'd0;
    logic [31:0] istream_b = 32'd0;
    logic [31:0] istream_n = 32'd0;
    logic        ostream_val;
    logic        ostream_rdy = 1'b1;
    logic [31:0] ostream_msg;

    int total  = 0;
    int passed = 0;

    rsa_xcel_naive_mulrem dut (
        .clk         (clk),
        .reset       (reset),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .istream_a   (istream_a),
        .istream_b   (istream_b),
        .istream_n   (istream_n),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .ostream_msg (ostream_msg)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] n;
        logic [31:0] exp;
        bit          chk_msg;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    endtask

    // Edges counted from the accepting edge (inclusive) to the edge after which ostream_val is seen.
    function automatic int exp_lat(input logic [31:0] b);
`ifdef RSA_XCEL_NAIVE_MULREM_EARLY_EXIT_EN
        int bl;
        bl = 0;
        for (int i = 0; i < 32; i++) if (b[i]) bl = i + 1;
        if (bl == 0) bl = 1;
        return 1 + bl;
`else
        return 33;
`endif
    endfunction

    task automatic start_req(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] n);
        @(negedge clk);
        istream_a   = a;
        istream_b   = b;
        istream_n   = n;
        istream_val = 1'b1;
        check({name, "_in_rdy"}, {31'd0, istream_rdy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        istream_val = 1'b0;
    endtask

    task automatic wait_val(output logic [31:0] msg, output int lat);
        lat = 1;
        while (!ostream_val && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        msg = ostream_msg;
    endtask

    logic [31:0] msg;
    int          lat;

    initial begin
        vecs[0]  = '{"r027_7x5m13",   32'd7,          32'd5,          32'd13,         32'd9,          1'b1};
        vecs[1]  = '{"r028_wide",     32'hFFFF_FFFE,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd1,          1'b1};
        vecs[2]  = '{"r032_nzero",    32'd0,          32'h0000_1234,  32'd0,          32'd0,          1'b1};
        vecs[3]  = '{"r030_b0",       32'd5,          32'd0,          32'd11,         32'd0,          1'b1};
        vecs[4]  = '{"r030_b5",       32'd7,          32'd5,          32'd13,         32'd9,          1'b1};
        vecs[5]  = '{"a0",            32'd0,          32'd12345,      32'd17,         32'd0,          1'b1};
        vecs[6]  = '{"10x10m11",      32'd10,         32'd10,         32'd11,         32'd1,          1'b1};
        vecs[7]  = '{"half_mod",      32'h7FFF_FFFF,  32'd2,          32'h8000_0000,  32'h7FFF_FFFE,  1'b1};
        vecs[8]  = '{"bmax_m1000",    32'd1,          32'hFFFF_FFFF,  32'd1000,       32'd295,        1'b1};
        vecs[9]  = '{"mid",           32'd123456,     32'd1000,       32'd1000003,    32'd455631,     1'b1};
        vecs[10] = '{"pow32",         32'd2,          32'h8000_0000,  32'hFFFF_FFFF,  32'd1,          1'b1};
        vecs[11] = '{"r021_a_ge_n",   32'd20,         32'd3,          32'd7,          32'd0,          1'b0};

        // Reset state while reset is held low.
        #1;
        check("rst_in_rdy",  {31'd0, istream_rdy}, 32'd1);
        check("rst_out_val", {31'd0, ostream_val}, 32'd0);
        check("rst_msg",     ostream_msg,          32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            ostream_rdy = 1'b1;
            start_req(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].n);
            wait_val(msg, lat);
            check({vecs[i].name, "_val"}, {31'd0, ostream_val}, 32'd1);
            check({vecs[i].name, "_lat"}, lat, exp_lat(vecs[i].b));
            if (vecs[i].chk_msg) check({vecs[i].name, "_msg"}, msg, vecs[i].exp);
            @(posedge clk);
            @(negedge clk);
            check({vecs[i].name, "_idle_rdy"}, {31'd0, istream_rdy}, 32'd1);
            check({vecs[i].name, "_idle_val"}, {31'd0, ostream_val}, 32'd0);
        end

        // Output back-pressure: result and handshake must hold while ostream_rdy is low.
        ostream_rdy = 1'b0;
        start_req("r029", 32'd12, 32'd1, 32'd13);
        wait_val(msg, lat);
        check("r029_val", {31'd0, ostream_val}, 32'd1);
        check("r029_lat", lat, exp_lat(32'd1));
        check("r029_msg", msg, 32'd12);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("r029_hold_val", {31'd0, ostream_val}, 32'd1);
            check("r029_hold_msg", ostream_msg, 32'd12);
            check("r029_hold_rdy", {31'd0, istream_rdy}, 32'd0);
        end
        ostream_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("r029_idle_rdy", {31'd0, istream_rdy}, 32'd1);
        check("r029_idle_val", {31'd0, ostream_val}, 32'd0);

        // Asynchronous reset in the middle of CALC, then a fresh request.
        start_req("r031a", 32'd3, 32'd9, 32'd7);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("r031_rst_val", {31'd0, ostream_val}, 32'd0);
        check("r031_rst_rdy", {31'd0, istream_rdy}, 32'd1);
        check("r031_rst_msg", ostream_msg, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        start_req("r031b", 32'd3, 32'd9, 32'd7);
        wait_val(msg, lat);
        check("r031_val", {31'd0, ostream_val}, 32'd1);
        check("r031_lat", lat, exp_lat(32'd9));
        check("r031_msg", msg, 32'd6);
        @(posedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

endmodule
